// File: rtl/yutorina_gpr_pkg.sv
// rtl/yutorina_gpr_pkg.sv - shared GPR constants, arbiter state encoding and widths
package yutorina_gpr_pkg;

    localparam int GPR_NUM        = 32;
    localparam int GPR_ADDR_W_DEF = 5;
    localparam int GPR_WORD_W_DEF = 32;

    localparam int STARVE_MAX_DEF = 4;
    // Must hold STARVE_MAX; 4 bits covers limits up to 15.
    localparam int STARVE_CNT_W   = 4;

    typedef enum logic [0:0] {
        ARB_NORMAL = 1'b0,
        ARB_FORCE  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/yutorina_gpr_scoreboard.sv
// rtl/yutorina_gpr_scoreboard.sv - busy vector for outstanding long-op destinations and hazard detect
module yutorina_gpr_scoreboard
    import yutorina_gpr_pkg::*;
#(
    parameter int ADDR_W = GPR_ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_iss_valid,
    input  logic [ADDR_W-1:0]    i_iss_addr,
    input  logic                 i_clr_valid,
    input  logic [ADDR_W-1:0]    i_clr_addr,
    input  logic [ADDR_W-1:0]    i_r_addr1,
    input  logic [ADDR_W-1:0]    i_r_addr2,
    output logic                 o_hazard,
    output logic [(1<<ADDR_W)-1:0] o_busy
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    // Clear first so a same-cycle issue to the retiring register keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_valid) begin
            w_busy_nxt[i_clr_addr] = 1'b0;
        end
        if (i_iss_valid && (i_iss_addr != '0)) begin
            w_busy_nxt[i_iss_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_hazard = ~rst & (r_busy[i_r_addr1] | r_busy[i_r_addr2]);
    assign o_busy   = r_busy;

endmodule

// File: rtl/yutorina_gpr_wb_arb.sv
// rtl/yutorina_gpr_wb_arb.sv - GPR write-port arbiter between pipeline write-back and long-latency unit
module yutorina_gpr_wb_arb
    import yutorina_gpr_pkg::*;
#(
    parameter int GPR_ADDR_W = GPR_ADDR_W_DEF,
    parameter int WORD_W     = GPR_WORD_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wb_valid,
    input  logic [GPR_ADDR_W-1:0] wb_addr,
    input  logic [WORD_W-1:0]     wb_data,
    output logic                  wb_stall,
    input  logic                  lu_valid,
    input  logic [GPR_ADDR_W-1:0] lu_addr,
    input  logic [WORD_W-1:0]     lu_data,
    output logic                  lu_ready,
    input  logic                  iss_valid,
    input  logic [GPR_ADDR_W-1:0] iss_addr,
    input  logic [GPR_ADDR_W-1:0] r_addr1,
    input  logic [GPR_ADDR_W-1:0] r_addr2,
    output logic                  hazard,
    output logic                  gpr_we_,
    output logic [GPR_ADDR_W-1:0] gpr_w_addr,
    output logic [WORD_W-1:0]     gpr_w_data
);

    localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);
    localparam logic [STARVE_CNT_W-1:0] CNT_ONE = STARVE_CNT_W'(1);

    arb_state_e                r_state;
    arb_state_e                w_state_nxt;
    logic [STARVE_CNT_W-1:0]   r_cnt;
    logic [STARVE_CNT_W-1:0]   w_cnt_nxt;
    logic [STARVE_CNT_W-1:0]   w_cnt_inc;
    logic                      w_grant_wb;
    logic                      w_grant_lu;
    logic                      w_lu_ready;
    logic                      w_wb_stall;
    logic [GPR_ADDR_W-1:0]     w_wr_addr;
    logic [WORD_W-1:0]         w_wr_data;
    logic [(1<<GPR_ADDR_W)-1:0] w_busy;

    logic                      r_gpr_we_n;
    logic [GPR_ADDR_W-1:0]     r_gpr_w_addr;
    logic [WORD_W-1:0]         r_gpr_w_data;

    assign w_cnt_inc = r_cnt + CNT_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant_wb  = 1'b0;
        w_lu_ready  = 1'b0;
        w_wb_stall  = 1'b0;
        if (!rst) begin
            case (r_state)
                ARB_NORMAL: begin
                    w_grant_wb = wb_valid & ~flush;
                    w_lu_ready = ~w_grant_wb;
                    if (lu_valid && !w_lu_ready) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) begin
                            w_state_nxt = ARB_FORCE;
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                ARB_FORCE: begin
                    // Pipeline is frozen so the starved unit drains unconditionally.
                    w_wb_stall = 1'b1;
                    w_lu_ready = lu_valid;
                    if (lu_valid) begin
                        w_state_nxt = ARB_NORMAL;
                        w_cnt_nxt   = '0;
                    end
                end
            endcase
        end
    end

    assign w_grant_lu = lu_valid & w_lu_ready;
    assign w_wr_addr  = w_grant_wb ? wb_addr : lu_addr;
    assign w_wr_data  = w_grant_wb ? wb_data : lu_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_NORMAL;
            r_cnt        <= '0;
            r_gpr_we_n   <= 1'b1;
            r_gpr_w_addr <= '0;
            r_gpr_w_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gpr_we_n <= ~((w_grant_wb | w_grant_lu) & (w_wr_addr != '0));
            if (w_grant_wb || w_grant_lu) begin
                r_gpr_w_addr <= w_wr_addr;
                r_gpr_w_data <= w_wr_data;
            end
        end
    end

    yutorina_gpr_scoreboard #(
        .ADDR_W (GPR_ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_iss_valid (iss_valid),
        .i_iss_addr  (iss_addr),
        .i_clr_valid (w_grant_lu),
        .i_clr_addr  (lu_addr),
        .i_r_addr1   (r_addr1),
        .i_r_addr2   (r_addr2),
        .o_hazard    (hazard),
        .o_busy      (w_busy)
    );

    // A write-back to a register still owed by the long unit would be overwritten out of order.
    a_wb_not_busy: assert property (@(posedge clk) disable iff (rst)
        (wb_valid && !flush) |-> !w_busy[wb_addr]);

    assign wb_stall   = w_wb_stall;
    assign lu_ready   = w_lu_ready;
    assign gpr_we_    = r_gpr_we_n;
    assign gpr_w_addr = r_gpr_w_addr;
    assign gpr_w_data = r_gpr_w_data;

endmodule

// File: tb/tb_yutorina_gpr_wb_arb.sv
// tb/tb_yutorina_gpr_wb_arb.sv - directed self-checking bench for yutorina_gpr_wb_arb
module tb_yutorina_gpr_wb_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [4:0]  r_addr1;
    logic [4:0]  r_addr2;
    logic        hazard;
    logic        gpr_we_;
    logic [4:0]  gpr_w_addr;
    logic [31:0] gpr_w_data;

    int passed = 0;
    int total  = 0;

    yutorina_gpr_wb_arb dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_stall   (wb_stall),
        .lu_valid   (lu_valid),
        .lu_addr    (lu_addr),
        .lu_data    (lu_data),
        .lu_ready   (lu_ready),
        .iss_valid  (iss_valid),
        .iss_addr   (iss_addr),
        .r_addr1    (r_addr1),
        .r_addr2    (r_addr2),
        .hazard     (hazard),
        .gpr_we_    (gpr_we_),
        .gpr_w_addr (gpr_w_addr),
        .gpr_w_data (gpr_w_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] a);
        iss_valid = 1'b1; iss_addr = a;
        tick();
        iss_valid = 1'b0; iss_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'h22;
        lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 32'h33;
        iss_valid = 1'b1; iss_addr = 5'd5; r_addr1 = 5'd5; r_addr2 = 5'd3;
        #1;
        total++; if (lu_ready !== 1'b0) $display("FAIL reset_lu_ready got=%b want=0", lu_ready); else passed++;
        total++; if (wb_stall !== 1'b0) $display("FAIL reset_wb_stall got=%b want=0", wb_stall); else passed++;
        total++; if (hazard !== 1'b0) $display("FAIL reset_hazard got=%b want=0", hazard); else passed++;
        tick(); tick();
        total++; if (gpr_we_ !== 1'b1) $display("FAIL reset_we got=%b want=1", gpr_we_); else passed++;
        total++; if (gpr_w_addr !== 5'd0) $display("FAIL reset_addr got=%0d want=0", gpr_w_addr); else passed++;
        total++; if (gpr_w_data !== 32'd0) $display("FAIL reset_data got=%0h want=0", gpr_w_data); else passed++;
        total++; if (hazard !== 1'b0) $display("FAIL reset_hazard_held got=%b want=0", hazard); else passed++;
        rst = 1'b0; wb_valid = 1'b0; lu_valid = 1'b0; iss_valid = 1'b0; iss_addr = '0;
        r_addr1 = '0; r_addr2 = '0;
        tick();
    endtask

    task automatic test_lu_basic();
        issue(5'd5);
        r_addr1 = 5'd5;
        lu_valid = 1'b1; lu_addr = 5'd5; lu_data = 32'h1234;
        #1;
        total++; if (hazard !== 1'b1) $display("FAIL lu_basic_hazard_set got=%b want=1", hazard); else passed++;
        total++; if (lu_ready !== 1'b1) $display("FAIL lu_basic_ready got=%b want=1", lu_ready); else passed++;
        tick();
        lu_valid = 1'b0;
        #1;
        total++; if (gpr_we_ !== 1'b0) $display("FAIL lu_basic_we got=%b want=0", gpr_we_); else passed++;
        total++; if (gpr_w_addr !== 5'd5) $display("FAIL lu_basic_addr got=%0d want=5", gpr_w_addr); else passed++;
        total++; if (gpr_w_data !== 32'h1234) $display("FAIL lu_basic_data got=%0h want=1234", gpr_w_data); else passed++;
        total++; if (hazard !== 1'b0) $display("FAIL lu_basic_hazard_clr got=%b want=0", hazard); else passed++;
        r_addr1 = '0;
        tick();
        total++; if (gpr_we_ !== 1'b1) $display("FAIL lu_basic_idle_we got=%b want=1", gpr_we_); else passed++;
    endtask

    task automatic test_wb_vs_lu();
        issue(5'd7);
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hA;
        lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'hB;
        #1;
        total++; if (lu_ready !== 1'b0) $display("FAIL wb_vs_lu_ready got=%b want=0", lu_ready); else passed++;
        total++; if (wb_stall !== 1'b0) $display("FAIL wb_vs_lu_stall got=%b want=0", wb_stall); else passed++;
        tick();
        wb_valid = 1'b0;
        #1;
        total++; if (gpr_we_ !== 1'b0 || gpr_w_addr !== 5'd3 || gpr_w_data !== 32'hA)
            $display("FAIL wb_vs_lu_first got=we%b/%0d/%0h want=we0/3/a", gpr_we_, gpr_w_addr, gpr_w_data); else passed++;
        total++; if (lu_ready !== 1'b1) $display("FAIL wb_vs_lu_ready2 got=%b want=1", lu_ready); else passed++;
        tick();
        lu_valid = 1'b0;
        #1;
        total++; if (gpr_we_ !== 1'b0 || gpr_w_addr !== 5'd7 || gpr_w_data !== 32'hB)
            $display("FAIL wb_vs_lu_second got=we%b/%0d/%0h want=we0/7/b", gpr_we_, gpr_w_addr, gpr_w_data); else passed++;
        tick();
    endtask

    task automatic test_starve();
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        issue(5'd7);
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'hAB;
        lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h77;
        for (int c = 0; c < 6; c++) begin
            #1;
            total++; if (wb_stall !== (c == 4)) $display("FAIL starve_stall_c%0d got=%b want=%b", c, wb_stall, (c == 4)); else passed++;
            total++; if (lu_ready !== (c == 4)) $display("FAIL starve_ready_c%0d got=%b want=%b", c, lu_ready, (c == 4)); else passed++;
            tick();
            if (c == 4) lu_valid = 1'b0;
            exp_addr = (c == 4) ? 5'd7 : 5'd4;
            exp_data = (c == 4) ? 32'h77 : 32'hAB;
            total++; if (gpr_we_ !== 1'b0 || gpr_w_addr !== exp_addr || gpr_w_data !== exp_data)
                $display("FAIL starve_write_c%0d got=we%b/%0d/%0h want=we0/%0d/%0h", c, gpr_we_, gpr_w_addr, gpr_w_data, exp_addr, exp_data);
            else passed++;
        end
        wb_valid = 1'b0;
        tick();
    endtask

    task automatic test_set_wins();
        issue(5'd9);
        iss_valid = 1'b1; iss_addr = 5'd9;
        lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h99;
        #1;
        total++; if (lu_ready !== 1'b1) $display("FAIL set_wins_ready got=%b want=1", lu_ready); else passed++;
        tick();
        iss_valid = 1'b0; iss_addr = '0; lu_valid = 1'b0;
        r_addr1 = 5'd9; r_addr2 = 5'd0;
        #1;
        total++; if (hazard !== 1'b1) $display("FAIL set_wins_hazard got=%b want=1", hazard); else passed++;
        total++; if (gpr_we_ !== 1'b0 || gpr_w_addr !== 5'd9) $display("FAIL set_wins_write got=we%b/%0d want=we0/9", gpr_we_, gpr_w_addr); else passed++;
        r_addr1 = 5'd0; r_addr2 = 5'd9;
        #1;
        total++; if (hazard !== 1'b1) $display("FAIL set_wins_hazard_a2 got=%b want=1", hazard); else passed++;
        lu_valid = 1'b1;
        tick();
        lu_valid = 1'b0;
        #1;
        total++; if (hazard !== 1'b0) $display("FAIL set_wins_cleared got=%b want=0", hazard); else passed++;
        r_addr2 = '0;
        tick();
    endtask

    task automatic test_addr0_flush();
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFF;
        tick();
        wb_valid = 1'b0;
        total++; if (gpr_we_ !== 1'b1) $display("FAIL addr0_wb_we got=%b want=1", gpr_we_); else passed++;
        lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'h55;
        #1;
        total++; if (lu_ready !== 1'b1) $display("FAIL addr0_lu_ready got=%b want=1", lu_ready); else passed++;
        tick();
        lu_valid = 1'b0;
        total++; if (gpr_we_ !== 1'b1) $display("FAIL addr0_lu_we got=%b want=1", gpr_we_); else passed++;
        issue(5'd0);
        r_addr1 = 5'd0;
        #1;
        total++; if (hazard !== 1'b0) $display("FAIL addr0_busy got=%b want=0", hazard); else passed++;
        issue(5'd6);
        flush = 1'b1; wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'h22;
        lu_valid = 1'b1; lu_addr = 5'd6; lu_data = 32'h66;
        #1;
        total++; if (lu_ready !== 1'b1) $display("FAIL flush_lu_ready got=%b want=1", lu_ready); else passed++;
        total++; if (wb_stall !== 1'b0) $display("FAIL flush_stall got=%b want=0", wb_stall); else passed++;
        tick();
        flush = 1'b0; wb_valid = 1'b0; lu_valid = 1'b0; r_addr1 = 5'd6;
        #1;
        total++; if (gpr_we_ !== 1'b0 || gpr_w_addr !== 5'd6 || gpr_w_data !== 32'h66)
            $display("FAIL flush_write got=we%b/%0d/%0h want=we0/6/66", gpr_we_, gpr_w_addr, gpr_w_data); else passed++;
        total++; if (hazard !== 1'b0) $display("FAIL flush_busy_clr got=%b want=0", hazard); else passed++;
        r_addr1 = '0;
        tick();
    endtask

    task automatic test_rst_in_force();
        issue(5'd7);
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'hCD;
        lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h70;
        r_addr1 = 5'd7;
        repeat (4) tick();
        #1;
        total++; if (wb_stall !== 1'b1) $display("FAIL rst_force_entered got=%b want=1", wb_stall); else passed++;
        rst = 1'b1;
        #1;
        total++; if (lu_ready !== 1'b0 || wb_stall !== 1'b0 || hazard !== 1'b0)
            $display("FAIL rst_force_during got=rdy%b/stall%b/haz%b want=0/0/0", lu_ready, wb_stall, hazard); else passed++;
        tick();
        rst = 1'b0; wb_valid = 1'b0; lu_valid = 1'b0;
        #1;
        total++; if (gpr_we_ !== 1'b1 || gpr_w_addr !== 5'd0 || gpr_w_data !== 32'd0)
            $display("FAIL rst_force_outputs got=we%b/%0d/%0h want=we1/0/0", gpr_we_, gpr_w_addr, gpr_w_data); else passed++;
        total++; if (wb_stall !== 1'b0) $display("FAIL rst_force_normal got=%b want=0", wb_stall); else passed++;
        total++; if (hazard !== 1'b0) $display("FAIL rst_force_busy got=%b want=0", hazard); else passed++;
        r_addr1 = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_lu_basic();
        test_wb_vs_lu();
        test_starve();
        test_set_wins();
        test_addr0_flush();
        test_rst_in_force();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
